sr04_dist_filter: RTL
=====================

# sr04_dist_filter

Post-processing stage directly downstream of the HC-SR04 ultrasonic driver. It consumes the driver's one-cycle `Dat_Rdy_Sig` pulse and 16-bit `Dist_mm` result, where 0 means echo timeout. It rejects out-of-range or timed-out samples, removes single-sample spikes with a 3-tap median, and smooths with a 4-tap moving average. It publishes a filtered distance, a validity flag and a lost-target flag to the altitude/fusion logic.

## Interface
- `MIN_MM`, 16'd20: smallest accepted distance (mm), inclusive.
- `MAX_MM`, 16'd4000: largest accepted distance (mm), inclusive.
- `LOST_N`, 3'd5: consecutive invalid samples that declare the target lost (1..7).
- `CLK` input 1: system clock; one clock domain only.
- `RST` input 1: reset, asynchronous and active-high.
- `Dat_Rdy_Sig` input 1: one-cycle pulse; `Dist_mm` is valid in the same cycle.
- `Dist_mm` input 16: raw distance in mm; 0 = timeout.
- `Filt_Rdy` output 1: one-cycle pulse; a new result is on `Filt_mm`/`Dist_Valid`/`Lost`.
- `Filt_mm` output 16: filtered distance in mm.
- `Dist_Valid` output 1: the sample behind the latest `Filt_Rdy` was accepted.
- `Lost` output 1: the target is lost, or no valid sample has arrived since reset.

## Operation
- FSM states: IDLE, CHECK, MEDIAN, AVG, OUT.
  - IDLE: on `Dat_Rdy_Sig`, latch `Dist_mm` into `samp`, then go to CHECK.
  - `Dat_Rdy_Sig` in any other state is dropped, with no side effects. The producer period is ≥ 100 ms.
- CHECK:
  - Valid iff `MIN_MM` ≤ `samp` ≤ `MAX_MM`. Zero is always invalid.
  - Invalid sample:
    - `miss_cnt` increments, saturating at 7.
    - If the new `miss_cnt` ≥ `LOST_N`: set `Lost`=1 and set `empty`=1 (history discarded).
    - Go to OUT with `Dist_Valid`=0 and `Filt_mm` unchanged.
  - Valid sample:
    - `miss_cnt`=0 and `Lost`=0.
    - If `empty`: load all 3 median taps and all 4 average taps with `samp`, set sum = `samp`·4, clear `empty`, go to MEDIAN.
    - Otherwise: shift `samp` into the median window (drop the oldest), go to MEDIAN.
- MEDIAN: register the median of the 3 taps as `med`. Comparisons are unsigned; if values are equal, either equal value is correct.
- AVG:
  - `sum` (18 bit) ← `sum` − `avg_buf[wr]` + `med`.
  - `avg_buf[wr]` ← `med`.
  - `wr` ← `wr`+1 mod 4, wrapping 3→0.
  - If `med` came from prefill, the update is a no-op numerically.
- OUT:
  - `Filt_mm` ← `sum[17:2]` (truncating divide by 4) on the valid path only.
  - `Filt_Rdy`=1 for one cycle.
  - `Dist_Valid` is set per path.
  - Return to IDLE.
- `sum` never overflows: 4·65535 < 2^18.

## Timing
- Reset values:
  - Outputs: `Filt_Rdy`=0, `Filt_mm`=0, `Dist_Valid`=0, `Lost`=1.
  - Internal: `miss_cnt`=0, `empty`=1, `wr`=0, `sum`=0, state IDLE.
- Valid path: `Dat_Rdy_Sig` is sampled at edge k → `Filt_Rdy` is high in the cycle after edge k+4, with `Filt_mm`/`Dist_Valid`/`Lost` updated at the same edge.
- Invalid path: `Filt_Rdy` is high in the cycle after edge k+2.
- Outputs are held between pulses. `Filt_Rdy` never stays high for two consecutive cycles.
- Earliest accepted next sample: the cycle after returning to IDLE (k+5 valid, k+3 invalid).
- Reset asserted mid-sequence: all registers return to reset values immediately, and no `Filt_Rdy` is produced for the aborted sample.

## Structure
- Shared package `sr04_pkg` holds:
  - FSM state encoding (localparams IDLE..OUT, 3 bit).
  - Default `SR04_MIN_MM`/`SR04_MAX_MM`, shared with the driver's range checks.
- One sub-module: `median3`, purely combinational with three 16-bit inputs and one 16-bit output. Its output is registered in the MEDIAN state.
- The average buffer is 4×16 registers plus an 18-bit running sum. No RAM and no divider.

## Test plan
- Reset, then 1000 → `Filt_Rdy` 4 edges later, `Filt_mm`=1000, `Dist_Valid`=1, `Lost`=0.
- 1000,1000,3000,1000 → four outputs of 1000. The spike is removed by the median.
- 1000,1004,1008,1012 → `Filt_mm` = 1000,1000,1001,1003 (checks truncation and `wr` wrap).
- 500 then five zeros → `Filt_mm` stays 500 with `Dist_Valid`=0. `Lost` rises on the 5th zero. Then 800 → 800, `Lost`=0, history reinitialised.
- 10, then 4500, then 4000 → first two invalid (`miss_cnt` 1, 2), third accepted at 4000. Boundary 20 is accepted, 19 is rejected.
- Pulse `Dat_Rdy_Sig` in CHECK → ignored. Separately, assert `RST` in AVG → outputs return to reset values and no `Filt_Rdy` is produced.

Source files
------------

// File: rtl/sr04_pkg.sv
// Shared HC-SR04 definitions: filter FSM state encoding and default range limits.
// Range defaults are common to the ranging driver and its downstream filter.
package sr04_pkg;

  typedef logic [2:0] sr04_state_t;

  localparam sr04_state_t IDLE   = 3'd0;
  localparam sr04_state_t CHECK  = 3'd1;
  localparam sr04_state_t MEDIAN = 3'd2;
  localparam sr04_state_t AVG    = 3'd3;
  localparam sr04_state_t OUT    = 3'd4;

  localparam logic [15:0] SR04_MIN_MM = 16'd20;
  localparam logic [15:0] SR04_MAX_MM = 16'd4000;
  localparam logic [2:0]  SR04_LOST_N = 3'd5;

  function automatic logic sr04_in_range(input logic [15:0] d, input logic [15:0] lo,
                                         input logic [15:0] hi);
    return (d != 16'd0) && (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/median3.sv
// Combinational unsigned median of three 16-bit values.
// Zero latency; no flow control.
module median3 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [15:0] c_i,
  output logic [15:0] med_o
);

  logic [15:0] lo_ab;
  logic [15:0] hi_ab;

  assign lo_ab = (a_i < b_i) ? a_i : b_i;
  assign hi_ab = (a_i < b_i) ? b_i : a_i;
  // c below the pair -> low of pair, above -> high of pair, else c itself.
  assign med_o = (c_i < lo_ab) ? lo_ab : ((c_i > hi_ab) ? hi_ab : c_i);

endmodule

// File: rtl/sr04_dist_filter.sv
// Range check, 3-tap median and 4-tap moving average on HC-SR04 distance samples.
// Result 4 edges after an accepted sample, 2 after a rejected one; pulses arriving mid-sequence are dropped.
module sr04_dist_filter
  import sr04_pkg::*;
#(
  parameter logic [15:0] MIN_MM = SR04_MIN_MM,
  parameter logic [15:0] MAX_MM = SR04_MAX_MM,
  parameter logic [2:0]  LOST_N = SR04_LOST_N
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Dat_Rdy_Sig,
  input  logic [15:0] Dist_mm,
  output logic        Filt_Rdy,
  output logic [15:0] Filt_mm,
  output logic        Dist_Valid,
  output logic        Lost
);

  sr04_state_t state_q;
  logic [15:0] samp_q;
  logic [2:0]  miss_q;
  logic        empty_q;
  logic        lost_q;
  logic        valid_q;
  logic [15:0] med_tap_q [3];
  logic [15:0] avg_buf_q [4];
  logic [17:0] sum_q;
  logic [1:0]  wr_q;
  logic [15:0] med_q;

  logic        filt_rdy_q;
  logic [15:0] filt_q;
  logic        dist_valid_q;
  logic        lost_out_q;

  logic        samp_ok_d;
  logic [2:0]  miss_d;
  logic [15:0] med_d;
  logic [17:0] sum_d;

  assign samp_ok_d = sr04_in_range(samp_q, MIN_MM, MAX_MM);
  assign miss_d    = (miss_q == 3'd7) ? 3'd7 : miss_q + 3'd1;
  // Running sum stays exact: the slot being removed is always part of sum_q.
  assign sum_d     = sum_q - {2'b00, avg_buf_q[wr_q]} + {2'b00, med_q};

  median3 u_median3 (
    .a_i  (med_tap_q[0]),
    .b_i  (med_tap_q[1]),
    .c_i  (med_tap_q[2]),
    .med_o(med_d)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      samp_q       <= '0;
      miss_q       <= '0;
      empty_q      <= 1'b1;
      lost_q       <= 1'b1;
      valid_q      <= 1'b0;
      sum_q        <= '0;
      wr_q         <= '0;
      med_q        <= '0;
      filt_rdy_q   <= 1'b0;
      filt_q       <= '0;
      dist_valid_q <= 1'b0;
      lost_out_q   <= 1'b1;
      for (int i = 0; i < 3; i++) med_tap_q[i] <= '0;
      for (int i = 0; i < 4; i++) avg_buf_q[i] <= '0;
    end else begin
      filt_rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Dat_Rdy_Sig) begin
            samp_q  <= Dist_mm;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (samp_ok_d) begin
            miss_q  <= '0;
            lost_q  <= 1'b0;
            valid_q <= 1'b1;
            if (empty_q) begin
              // Fresh history: prefill so the first output equals the sample.
              for (int i = 0; i < 3; i++) med_tap_q[i] <= samp_q;
              for (int i = 0; i < 4; i++) avg_buf_q[i] <= samp_q;
              sum_q   <= {samp_q, 2'b00};
              empty_q <= 1'b0;
            end else begin
              med_tap_q[2] <= med_tap_q[1];
              med_tap_q[1] <= med_tap_q[0];
              med_tap_q[0] <= samp_q;
            end
            state_q <= MEDIAN;
          end else begin
            miss_q  <= miss_d;
            valid_q <= 1'b0;
            if (miss_d >= LOST_N) begin
              lost_q  <= 1'b1;
              empty_q <= 1'b1;
            end
            state_q <= OUT;
          end
        end
        MEDIAN: begin
          med_q   <= med_d;
          state_q <= AVG;
        end
        AVG: begin
          sum_q           <= sum_d;
          avg_buf_q[wr_q] <= med_q;
          wr_q            <= wr_q + 2'd1;
          state_q         <= OUT;
        end
        OUT: begin
          filt_rdy_q   <= 1'b1;
          dist_valid_q <= valid_q;
          lost_out_q   <= lost_q;
          if (valid_q) filt_q <= sum_q[17:2];
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Filt_Rdy   = filt_rdy_q;
  assign Filt_mm    = filt_q;
  assign Dist_Valid = dist_valid_q;
  assign Lost       = lost_out_q;

endmodule
